// File: rtl/rr_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_bus_arbiter_pkg
// Purpose  : Shared constants and types for the round-robin write-back bus
//            arbiter: requester IDs, default widths and the output state.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rr_bus_arbiter_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_REQS  = 4;
    localparam int DEF_SRCW  = 2;

    // Requester IDs, also the word-select codes of the output mux
    localparam logic [DEF_SRCW-1:0] SRC_ALU = 2'd0;
    localparam logic [DEF_SRCW-1:0] SRC_SHF = 2'd1;
    localparam logic [DEF_SRCW-1:0] SRC_LD  = 2'd2;
    localparam logic [DEF_SRCW-1:0] SRC_STR = 2'd3;

    // Output register occupancy; FULL is exactly out_valid=1
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage : rr_bus_arbiter_pkg
`default_nettype wire

// File: rtl/rr_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_bus_arbiter_if
// Purpose  : Requester-side and downstream-side handshake bundle of the
//            arbiter.
// Ports    : req_valid/req_data/req_ready  - requester valid/ready channel
//            out_valid/out_data/out_src/out_ready - downstream channel
//            modport slave  : the arbiter's view
//            modport master : the environment's view (requesters + sink)
// Revision : 1.0 - initial release
// ============================================================================
interface rr_bus_arbiter_if
    import rr_bus_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int REQS  = DEF_REQS,
    parameter int SRCW  = DEF_SRCW
);
    logic [REQS-1:0]       req_valid;
    logic [WIDTH*REQS-1:0] req_data;
    logic [REQS-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SRCW-1:0]       out_src;
    logic                  out_ready;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );
endinterface : rr_bus_arbiter_if
`default_nettype wire

// File: rtl/rr_bus_arbiter_pick4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Purpose  : Rotate-priority encoder: first set request scanning from ptr
//            upward, wrapping modulo 4.
// Ports    : req - request vector, ptr - highest-priority index,
//            gnt - one-hot grant, idx - grant index, any - some request set
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick4 (
    input  wire logic [3:0] req,
    input  wire logic [1:0] ptr,
    output logic      [3:0] gnt,
    output logic      [1:0] idx,
    output logic            any
);
    logic [1:0] w_cand;

    // Scan from the lowest priority up so the highest-priority hit is the
    // last one written.
    always_comb begin
        idx    = ptr;
        w_cand = ptr;
        for (int k = 3; k >= 0; k--) begin
            w_cand = ptr + 2'(k);
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
        any = |req;
        gnt = any ? (4'b0001 << idx) : 4'b0000;
    end
endmodule : rr_pick4
`default_nettype wire

// File: rtl/rr_bus_arbiter_wmux.sv
`default_nettype none
// ============================================================================
// Module   : rr_wmux4
// Purpose  : 4-input word mux built as AND-OR gating with decoded selects.
// Ports    : d0..d3 - input words, sel - word index, y - selected word
// Revision : 1.0 - initial release
// ============================================================================
module rr_wmux4
    import rr_bus_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic [WIDTH-1:0] d0,
    input  wire logic [WIDTH-1:0] d1,
    input  wire logic [WIDTH-1:0] d2,
    input  wire logic [WIDTH-1:0] d3,
    input  wire logic [1:0]       sel,
    output logic      [WIDTH-1:0] y
);
    assign y = ({WIDTH{sel == SRC_ALU}} & d0)
             | ({WIDTH{sel == SRC_SHF}} & d1)
             | ({WIDTH{sel == SRC_LD }} & d2)
             | ({WIDTH{sel == SRC_STR}} & d3);
endmodule : rr_wmux4
`default_nettype wire

// File: rtl/rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_bus_arbiter
// Purpose  : Round-robin arbiter sharing one registered write-back bus
//            between four valid/ready requesters, one word per cycle.
// Ports    : clk   - rising-edge clock
//            reset - asynchronous active-high reset
//            bus   - rr_bus_arbiter_if.slave (requester + downstream channels)
// Revision : 1.0 - initial release
// ============================================================================
module rr_bus_arbiter
    import rr_bus_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SRCW  = DEF_SRCW
) (
    input  wire logic        clk,
    input  wire logic        reset,
    rr_bus_arbiter_if.slave  bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic [SRCW-1:0]  r_out_src;

    logic [3:0]       w_gnt;
    logic [1:0]       w_gidx;
    logic             w_any;
    logic             w_can_load;
    logic             w_load;
    logic [WIDTH-1:0] w_word;

    rr_pick4 u_pick (
        .req (bus.req_valid),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_gidx),
        .any (w_any)
    );

    rr_wmux4 #(.WIDTH(WIDTH)) u_wmux (
        .d0  (bus.req_data[WIDTH*0 +: WIDTH]),
        .d1  (bus.req_data[WIDTH*1 +: WIDTH]),
        .d2  (bus.req_data[WIDTH*2 +: WIDTH]),
        .d3  (bus.req_data[WIDTH*3 +: WIDTH]),
        .sel (w_gidx),
        .y   (w_word)
    );

    // out_ready only reaches req_ready; the registered outputs never see it
    // combinationally.
    assign w_can_load    = (r_state == ST_EMPTY) || bus.out_ready;
    assign w_load        = w_can_load && w_any;
    assign bus.req_ready = w_load ? w_gnt : 4'b0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_load)        w_state_nxt = ST_FULL;
            ST_FULL:  if (w_load)        w_state_nxt = ST_FULL;
                      else if (bus.out_ready) w_state_nxt = ST_EMPTY;
            default:                     w_state_nxt = ST_EMPTY;
        endcase
    end

    // Data/source hold their last value on drain; only a capture changes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr      <= 2'd0;
            r_out_data <= '0;
            r_out_src  <= '0;
        end else if (w_load) begin
            r_ptr      <= w_gidx + 2'd1;
            r_out_data <= w_word;
            r_out_src  <= SRCW'(w_gidx);
        end
    end

    assign bus.out_valid = (r_state == ST_FULL);
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
endmodule : rr_bus_arbiter
`default_nettype wire

// File: tb/tb_rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_bus_arbiter
// Purpose  : Self-checking bench for rr_bus_arbiter with a behavioural model
//            and directed scenarios.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    rr_bus_arbiter_if bus ();

    rr_bus_arbiter dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // ---------------- behavioural model ----------------
    int          m_ptr;
    logic        m_valid;
    logic [31:0] m_data;
    logic [1:0]  m_src;
    int          m_g;

    function automatic int winner(logic [3:0] v, int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        g = winner(bus.req_valid, m_ptr);
        if ((!m_valid || bus.out_ready) && g >= 0) return 4'b0001 << g;
        return 4'b0000;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = '0;
        end else begin
            m_g = winner(bus.req_valid, m_ptr);
            if ((!m_valid || bus.out_ready) && m_g >= 0) begin
                m_valid = 1'b1;
                m_data  = bus.req_data[32*m_g +: 32];
                m_src   = m_g[1:0];
                m_ptr   = (m_g + 1) % 4;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready", 32'(bus.req_ready), 32'(exp_ready()));
            chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("out_data",  bus.out_data,       m_data);
            chk("out_src",   32'(bus.out_src),   32'(m_src));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_word(input int i, input logic [31:0] w);
        bus.req_data[32*i +: 32] = w;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        after_edge();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        after_edge();
        after_edge();
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  bus.out_data,       32'd0);
        chk("rst_out_src",   32'(bus.out_src),   32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        after_edge();
        rst = 1'b0;

        // Single requester 2
        bus.req_valid = 4'b0100;
        set_word(2, 32'hDEADBEEF);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t1_ready", 32'(bus.req_ready), 32'h4);
        after_edge();
        bus.req_valid = 4'b0000;
        @(negedge clk);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_data",  bus.out_data,       32'hDEADBEEF);
        chk("t1_src",   32'(bus.out_src),   32'd2);
        chk("t1_model_ptr", 32'(m_ptr),     32'd3);
        after_edge();

        // All four requesting, back-to-back
        pulse_reset();
        for (int i = 0; i < 4; i++) set_word(i, 32'h1000_0000 + 32'(i));
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t2_onehot", 32'($countones(bus.req_ready)), 32'd1);
            chk("t2_grant",  32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
            if (k > 0) begin
                chk("t2_src",  32'(bus.out_src), 32'((k - 1) % 4));
                chk("t2_data", bus.out_data, 32'h1000_0000 + 32'((k - 1) % 4));
            end
        end
        after_edge();
        bus.req_valid = 4'b1001;
        @(negedge clk);
        chk("t2_last_src", 32'(bus.out_src), 32'd3);

        // Pointer wrap: ptr=0 after grant 3, requesters 0 and 3
        chk("t4_ready0", 32'(bus.req_ready), 32'h1);
        after_edge();
        @(negedge clk);
        chk("t4_src0",   32'(bus.out_src),   32'd0);
        chk("t4_ready3", 32'(bus.req_ready), 32'h8);
        after_edge();
        bus.req_valid = 4'b0000;
        @(negedge clk);
        chk("t4_src3",   32'(bus.out_src),   32'd3);
        after_edge();

        // Stall holding requester 1's word; requester 2 flickers during stall
        set_word(1, 32'hAAAA_0001);
        set_word(2, 32'hBBBB_0002);
        set_word(3, 32'hCCCC_0003);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("t3_ready1", 32'(bus.req_ready), 32'h2);
        after_edge();
        bus.req_valid = 4'b1001;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = (k == 1) ? 4'b1101 : 4'b1001;
            @(negedge clk);
            chk("t3_stall_ready", 32'(bus.req_ready), 32'h0);
            chk("t3_stall_data",  bus.out_data,       32'hAAAA_0001);
            chk("t3_stall_src",   32'(bus.out_src),   32'd1);
            after_edge();
        end
        bus.req_valid = 4'b1001;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t3_resume_ready", 32'(bus.req_ready), 32'h8);
        after_edge();
        bus.req_valid = 4'b0000;
        @(negedge clk);
        chk("t3_resume_src",  32'(bus.out_src), 32'd3);
        chk("t3_resume_data", bus.out_data,     32'hCCCC_0003);
        after_edge();
        @(negedge clk);
        chk("t6_drained", 32'(bus.out_valid), 32'd0);
        chk("t6_no_grant2", 32'(bus.out_src), 32'd3);

        // Asynchronous reset while stalled
        after_edge();
        bus.req_valid = 4'b0100;
        after_edge();
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t5_pre_valid", 32'(bus.out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_valid", 32'(bus.out_valid), 32'd0);
        after_edge();
        rst = 1'b0;
        bus.req_valid = 4'b0010;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t5_ready1", 32'(bus.req_ready), 32'h2);
        after_edge();
        bus.req_valid = 4'b0000;
        @(negedge clk);
        chk("t5_src", 32'(bus.out_src), 32'd1);
        after_edge();
        after_edge();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule : tb_rr_bus_arbiter
`default_nettype wire
